// File: rtl/clk_seq_pkg.sv
// Shared types and default constants for the clock-lock sequencer.
package clk_seq_pkg;

  localparam int FBDIV_WIDTH_DEF  = 5;
  localparam int FBDIV_RST_DEF    = 10;
  localparam int GATE_GAP_DEF     = 8;
  localparam int LOCK_STABLE_DEF  = 64;
  localparam int LOCK_TIMEOUT_DEF = 4096;
  localparam int CNT_WIDTH_DEF    = 13;

  typedef enum logic [2:0] {
    ST_OFF,
    ST_GATE,
    ST_PROG,
    ST_WAIT_LOCK,
    ST_RUN,
    ST_FAIL
  } state_e;

  typedef struct packed {
    logic [FBDIV_WIDTH_DEF-1:0] fbdiv;
    logic                       byp;
  } cfg_t;

endpackage

// File: rtl/clk_lock_filter.sv
// Two-flop synchronizer for the PLL lock plus a saturating consecutive-high counter.
module clk_lock_filter #(
  parameter int LOCK_STABLE = 64,
  parameter int CNT_WIDTH   = 13
) (
  input  logic clk,
  input  logic rst_n,
  input  logic lock_async_i,
  input  logic clr_i,
  output logic lock_sync_o,
  output logic lock_stable_o
);

  localparam logic [CNT_WIDTH-1:0] STABLE_MAX = CNT_WIDTH'(LOCK_STABLE);

  logic                 meta_q;
  logic                 sync_q;
  logic [CNT_WIDTH-1:0] stable_q;
  logic [CNT_WIDTH-1:0] stable_d;

  // Count stops at the release threshold so it can never wrap back below it.
  always_comb begin
    stable_d = stable_q;
    if (clr_i || !sync_q) begin
      stable_d = '0;
    end else if (stable_q != STABLE_MAX) begin
      stable_d = stable_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q   <= 1'b0;
      sync_q   <= 1'b0;
      stable_q <= '0;
    end else begin
      meta_q   <= lock_async_i;
      sync_q   <= meta_q;
      stable_q <= stable_d;
    end
  end

  assign lock_sync_o   = sync_q;
  assign lock_stable_o = (stable_q == STABLE_MAX);

endmodule

// File: rtl/clk_lock_seq.sv
// Clock-config sequencer: gates the system clock, programs the PLL, releases on stable lock.
// Optional CLKSEQ_BYP_FALLBACK_EN: lock timeout falls back to bypass and runs instead of halting.
module clk_lock_seq
  import clk_seq_pkg::*;
#(
  parameter int FBDIV_WIDTH  = FBDIV_WIDTH_DEF,
  parameter int FBDIV_RST    = FBDIV_RST_DEF,
  parameter int GATE_GAP     = GATE_GAP_DEF,
  parameter int LOCK_STABLE  = LOCK_STABLE_DEF,
  parameter int LOCK_TIMEOUT = LOCK_TIMEOUT_DEF,
  parameter int CNT_WIDTH    = CNT_WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   I_CfgVld,
  input  logic [FBDIV_WIDTH-1:0] I_CfgFBDIV,
  input  logic                   I_CfgByp,
  output logic                   O_CfgRdy,
  input  logic                   I_PLLLock,
  output logic [FBDIV_WIDTH-1:0] O_FBDIV,
  output logic                   O_BypPLL,
  output logic                   O_SwClk,
  output logic                   O_Busy,
  output logic                   O_Fail,
  output state_e                 O_DbgState
);

  // Handshake: a config transfers on any rising clk edge with I_CfgVld & O_CfgRdy;
  // I_CfgVld and the cfg fields must stay stable until that edge.

  localparam logic [CNT_WIDTH-1:0] GAP_LAST  = CNT_WIDTH'(GATE_GAP - 1);
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_C = CNT_WIDTH'(LOCK_TIMEOUT);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

  state_e                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d, cnt_inc;
  cfg_t                   cfg_q, cfg_d;
  logic [FBDIV_WIDTH-1:0] fbdiv_q, fbdiv_d;
  logic                   byp_q, byp_d;
  logic                   fail_q, fail_d;
  logic                   swclk_q, swclk_d;
  logic                   busy_q, busy_d;
  logic                   rdy_q, rdy_d;
  logic                   accept;
  logic                   lock_sync, lock_stable, lock_clr;

  clk_lock_filter #(
    .LOCK_STABLE (LOCK_STABLE),
    .CNT_WIDTH   (CNT_WIDTH)
  ) u_filter (
    .clk           (clk),
    .rst_n         (rst_n),
    .lock_async_i  (I_PLLLock),
    .clr_i         (lock_clr),
    .lock_sync_o   (lock_sync),
    .lock_stable_o (lock_stable)
  );

  assign accept   = I_CfgVld & rdy_q;
  assign cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_WIDTH'(1);
  assign lock_clr = (state_d == ST_WAIT_LOCK) && (state_q != ST_WAIT_LOCK);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cfg_d   = cfg_q;
    fbdiv_d = fbdiv_q;
    byp_d   = byp_q;
    fail_d  = fail_q;
    case (state_q)
      ST_GATE: begin
        cnt_d = cnt_inc;
        if (cnt_q == GAP_LAST) begin
          state_d = ST_PROG;
          cnt_d   = '0;
          fbdiv_d = cfg_q.fbdiv;
          byp_d   = cfg_q.byp;
        end
      end
      ST_PROG: begin
        cnt_d = cnt_inc;
        if (cnt_q == GAP_LAST) begin
          state_d = cfg_q.byp ? ST_RUN : ST_WAIT_LOCK;
          cnt_d   = '0;
        end
      end
      ST_WAIT_LOCK: begin
        cnt_d = cnt_inc;
        // Stable lock wins over a timeout landing on the same cycle.
        if (lock_stable) begin
          state_d = ST_RUN;
        end else if (cnt_q == TIMEOUT_C) begin
          fail_d = 1'b1;
`ifdef CLKSEQ_BYP_FALLBACK_EN
          byp_d   = 1'b1;
          state_d = ST_RUN;
`else
          state_d = ST_FAIL;
`endif
        end
      end
      ST_RUN: begin
        if (!byp_q && !lock_sync) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end
      end
      default: ;
    endcase
    // A new config from any idle state overrides everything, including lock loss in RUN.
    if (accept) begin
      state_d = ST_GATE;
      cnt_d   = '0;
      cfg_d   = '{fbdiv: I_CfgFBDIV, byp: I_CfgByp};
      fail_d  = 1'b0;
    end
  end

  always_comb begin
    swclk_d = (state_d == ST_RUN);
    busy_d  = (state_d == ST_GATE) || (state_d == ST_PROG) || (state_d == ST_WAIT_LOCK);
    rdy_d   = (state_d == ST_OFF) || (state_d == ST_RUN) || (state_d == ST_FAIL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_OFF;
      cnt_q   <= '0;
      cfg_q   <= '{fbdiv: FBDIV_WIDTH_DEF'(FBDIV_RST), byp: 1'b1};
      fbdiv_q <= FBDIV_WIDTH'(FBDIV_RST);
      byp_q   <= 1'b1;
      fail_q  <= 1'b0;
      swclk_q <= 1'b0;
      busy_q  <= 1'b0;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cfg_q   <= cfg_d;
      fbdiv_q <= fbdiv_d;
      byp_q   <= byp_d;
      fail_q  <= fail_d;
      swclk_q <= swclk_d;
      busy_q  <= busy_d;
      rdy_q   <= rdy_d;
    end
  end

  assign O_CfgRdy   = rdy_q;
  assign O_FBDIV    = fbdiv_q;
  assign O_BypPLL   = byp_q;
  assign O_SwClk    = swclk_q;
  assign O_Busy     = busy_q;
  assign O_Fail     = fail_q;
  assign O_DbgState = state_q;

endmodule

// File: tb/tb_clk_lock_seq.sv
// Bench for clk_lock_seq: cycle model compared every cycle plus directed literal checks.
// Honours CLKSEQ_BYP_FALLBACK_EN for the lock-timeout outcome.
module tb_clk_lock_seq;
  import clk_seq_pkg::*;

  localparam int GAP = 8, STABLE = 64, TIMEOUT = 4096;
  localparam int MD_OFF = 0, MD_GATE = 1, MD_PROG = 2, MD_WAIT = 3, MD_RUN = 4, MD_FAIL = 5;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       vld = 1'b0;
  logic [4:0] cfg_fb = '0;
  logic       cfg_byp = 1'b0;
  logic       lock = 1'b0;
  logic       rdy, byp, swclk, busy, fail;
  logic [4:0] fbdiv;
  state_e     dbg_state;

  clk_lock_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .I_CfgVld   (vld),
    .I_CfgFBDIV (cfg_fb),
    .I_CfgByp   (cfg_byp),
    .O_CfgRdy   (rdy),
    .I_PLLLock  (lock),
    .O_FBDIV    (fbdiv),
    .O_BypPLL   (byp),
    .O_SwClk    (swclk),
    .O_Busy     (busy),
    .O_Fail     (fail),
    .O_DbgState (dbg_state)
  );

  int n_chk = 0, n_pass = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_chk++;
    if (act >= lo && act <= hi) n_pass++;
    else $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
  endtask

  // behavioural model: phase, time-in-phase, lock streak, lock delayed two edges
  int         m_mode, m_elapsed, m_streak;
  logic       m_d0, m_d1, m_byp, m_cbyp, m_fail;
  logic [4:0] m_fbdiv, m_cfb;

  function automatic logic m_rdy();
    return (m_mode == MD_OFF) || (m_mode == MD_RUN) || (m_mode == MD_FAIL);
  endfunction

  function automatic logic [9:0] m_vec();
    logic b;
    b = (m_mode == MD_GATE) || (m_mode == MD_PROG) || (m_mode == MD_WAIT);
    return {m_fbdiv, m_byp, (m_mode == MD_RUN), b, m_fail, m_rdy()};
  endfunction

  task automatic m_reset();
    m_mode = MD_OFF; m_elapsed = 0; m_streak = 0;
    m_d0 = 1'b0; m_d1 = 1'b0;
    m_fbdiv = 5'd10; m_byp = 1'b1; m_fail = 1'b0;
    m_cfb = 5'd10; m_cbyp = 1'b1;
  endtask

  task automatic m_step();
    logic lk, acc;
    lk = m_d1; m_d1 = m_d0; m_d0 = lock;
    acc = vld && m_rdy();
    if (acc) begin
      m_cfb = cfg_fb; m_cbyp = cfg_byp; m_fail = 1'b0;
      m_mode = MD_GATE; m_elapsed = 0;
    end else begin
      case (m_mode)
        MD_RUN: if (!m_byp && !lk) begin m_mode = MD_WAIT; m_elapsed = 0; m_streak = 0; end
        MD_GATE: begin
          m_elapsed++;
          if (m_elapsed == GAP) begin m_mode = MD_PROG; m_elapsed = 0; m_fbdiv = m_cfb; m_byp = m_cbyp; end
        end
        MD_PROG: begin
          m_elapsed++;
          if (m_elapsed == GAP) begin m_elapsed = 0; m_streak = 0; m_mode = m_cbyp ? MD_RUN : MD_WAIT; end
        end
        MD_WAIT: begin
          if (m_streak == STABLE) m_mode = MD_RUN;
          else if (m_elapsed == TIMEOUT) begin
            m_fail = 1'b1;
`ifdef CLKSEQ_BYP_FALLBACK_EN
            m_byp = 1'b1; m_mode = MD_RUN;
`else
            m_mode = MD_FAIL;
`endif
          end else begin
            m_streak = lk ? m_streak + 1 : 0;
            m_elapsed++;
          end
        end
        default: ;
      endcase
    end
  endtask

  // driver tasks
  task automatic goto(input int e);
    while (cyc < e) begin @(posedge clk); #1; end
  endtask

  task automatic at_edge(input int e);
    goto(e);
    @(negedge clk);
  endtask

  task automatic send_cfg(input logic [4:0] fb, input logic b, output int acc);
    cfg_fb = fb; cfg_byp = b; vld = 1'b1; acc = -1;
    for (int i = 0; i < 100; i++) begin
      if (rdy) begin @(posedge clk); #1; acc = cyc; break; end
      @(posedge clk); #1;
    end
    vld = 1'b0;
    if (acc < 0) begin check("accept_timeout", 0, 1); acc = cyc; end
  endtask

  task automatic wait_swclk(input logic val, input int bound, output int e);
    e = -1;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (swclk == val) begin e = cyc; break; end
    end
    if (e < 0) begin check("swclk_wait_timeout", 0, 1); e = cyc; end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_fbdiv"}, fbdiv, 10);
    check({tag, "_byp"}, byp, 1);
    check({tag, "_swclk"}, swclk, 0);
    check({tag, "_rdy"}, rdy, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_fail"}, fail, 0);
  endtask

  initial begin
    int a, e, d, r, x, f, tog;
    m_reset();
    fork
      forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) m_reset(); else m_step();
      end
      forever begin
        @(negedge clk);
        check("cycle_vs_model", int'({fbdiv, byp, swclk, busy, fail, rdy}), int'(m_vec()));
      end
      begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
      end
    join_none

    // reset and idle
    #1 rst_n = 1'b0;
    #2 check_reset_vals("in_reset");
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    at_edge(cyc + 20);
    check_reset_vals("idle");

    // PLL config, lock arrives 30 cycles after accept
    goto(cyc + 1);
    send_cfg(5'd20, 1'b0, a);
    at_edge(a + 7);
    check("pll_fbdiv_before", fbdiv, 10);
    at_edge(a + 8);
    check("pll_fbdiv_loaded", fbdiv, 20);
    check("pll_byp_loaded", byp, 0);
    goto(a + 29);
    lock = 1'b1;
    wait_swclk(1'b1, 200, e);
    check_range("pll_release_delay", e - a, 94, 96);
    check("pll_busy_after", busy, 0);

    // lock loss in RUN and recovery
    goto(cyc + 1);
    d = cyc;
    lock = 1'b0;
    at_edge(d + 2);
    check("loss_swclk_still_on", swclk, 1);
    at_edge(d + 3);
    check("loss_swclk_off", swclk, 0);
    goto(d + 10);
    r = d + 10;
    lock = 1'b1;
    at_edge(r + 66);
    check("relock_not_yet", swclk, 0);
    at_edge(r + 67);
    check("relock_release", swclk, 1);

    // bypass config; lock ignored afterwards
    goto(cyc + 1);
    send_cfg(5'd7, 1'b1, a);
    at_edge(a + 7);
    check("byp_before", byp, 0);
    at_edge(a + 8);
    check("byp_loaded", byp, 1);
    check("byp_fbdiv_loaded", fbdiv, 7);
    at_edge(a + 15);
    check("byp_swclk_before", swclk, 0);
    at_edge(a + 16);
    check("byp_swclk_on", swclk, 1);
    goto(a + 20);
    lock = 1'b0;
    at_edge(a + 40);
    check("byp_ignores_lock", swclk, 1);

    // lock drop coinciding with accept: accept wins
    goto(cyc + 1);
    lock = 1'b1;
    send_cfg(5'd12, 1'b0, a);
    wait_swclk(1'b1, 300, e);
    check("steady_lock_release", e - a, 81);
    goto(cyc + 1);
    x = cyc;
    lock = 1'b0;
    goto(x + 2);
    send_cfg(5'd3, 1'b1, a);
    check("race_accept_edge", a - x, 3);
    at_edge(x + 3);
    check("race_busy", busy, 1);
    check("race_rdy", rdy, 0);
    at_edge(x + 11);
    check("race_fbdiv", fbdiv, 3);
    at_edge(x + 19);
    check("race_swclk", swclk, 1);

    // lock toggling every 40 cycles never qualifies: timeout
    goto(cyc + 1);
    send_cfg(5'd9, 1'b0, a);
    f = -1; tog = 0;
    for (int i = 0; i < 4500; i++) begin
      @(posedge clk); #1;
      tog++;
      if (tog == 40) begin lock = ~lock; tog = 0; end
      if (fail) begin f = cyc; break; end
    end
    if (f < 0) begin check("timeout_never_fired", 0, 1); f = cyc; end
    check_range("timeout_len", f - (a + 16), TIMEOUT, TIMEOUT + 1);
    @(negedge clk);
    check("timeout_fail", fail, 1);
`ifdef CLKSEQ_BYP_FALLBACK_EN
    check("timeout_byp", byp, 1);
    check("timeout_swclk", swclk, 1);
`else
    check("timeout_byp", byp, 0);
    check("timeout_swclk", swclk, 0);
    check("timeout_rdy", rdy, 1);
`endif

    // reset in the middle of PROG, then a clean config
    goto(cyc + 1);
    send_cfg(5'd25, 1'b1, a);
    at_edge(a + 10);
    check("prog_fbdiv", fbdiv, 25);
    check("prog_fail_cleared", fail, 0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_reset_vals("mid_prog_reset");
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    send_cfg(5'd4, 1'b1, a);
    at_edge(a + 15);
    check("post_reset_swclk_off", swclk, 0);
    at_edge(a + 16);
    check("post_reset_swclk_on", swclk, 1);
    check("post_reset_fbdiv", fbdiv, 4);
    check("post_reset_byp", byp, 1);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
